// File: rtl/cache_stats.sv
// cache_stats: saturating L1 access counters plus a bit-serial restoring hit-ratio divider; STATS_FETCH_EN adds ifetch counting.
// Counters update 1 cycle after the access; print -> done takes FRAC_W+2 cycles; prints arriving while busy are dropped.
module cache_stats #(
  parameter int CNT_W  = 32,
  parameter int FRAC_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic [3:0]        n,
  input  logic              hit,
  input  logic              miss,
  output logic [CNT_W-1:0]  reads,
  output logic [CNT_W-1:0]  writes,
  output logic [CNT_W-1:0]  hits,
  output logic [CNT_W-1:0]  misses,
  output logic [CNT_W-1:0]  fetches,
  output logic [CNT_W-1:0]  snap_hits,
  output logic [CNT_W-1:0]  snap_misses,
  output logic [FRAC_W:0]   ratio,
  output logic              busy,
  output logic              done,
  output logic              proto_err
);

  localparam logic [3:0] OP_READ  = 4'd0;
  localparam logic [3:0] OP_WRITE = 4'd1;
  localparam logic [3:0] OP_CLEAR = 4'd8;
  localparam logic [3:0] OP_PRINT = 4'd9;
  localparam int         STEP_W   = $clog2(FRAC_W + 1);

  typedef enum logic [1:0] {IDLE, DIV, FIN} state_t;

  state_t              state, state_nxt;
  logic                counted, clear, print;
  logic [CNT_W:0]      divisor;
  logic [CNT_W+1:0]    rem, rem_sub;
  logic [FRAC_W:0]     quo;
  logic [STEP_W-1:0]   step;
  logic                q_bit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  always_comb begin
    counted = valid && ((n == OP_READ) || (n == OP_WRITE));
`ifdef STATS_FETCH_EN
    counted = counted || (valid && (n == 4'd2));
`endif
    clear = valid && (n == OP_CLEAR);
    print = valid && (n == OP_PRINT);
  end

  // A dual hit+miss strobe is a protocol error; it is counted as a hit only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reads  <= '0;
      writes <= '0;
      hits   <= '0;
      misses <= '0;
    end else if (clear) begin
      reads  <= '0;
      writes <= '0;
      hits   <= '0;
      misses <= '0;
    end else begin
      reads  <= sat_inc(reads,  counted && (n == OP_READ));
      writes <= sat_inc(writes, counted && (n == OP_WRITE));
      hits   <= sat_inc(hits,   counted && hit);
      misses <= sat_inc(misses, counted && miss && !hit);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) proto_err <= 1'b0;
    else if (counted && hit && miss) proto_err <= 1'b1;
  end

`ifdef STATS_FETCH_EN
  always_ff @(posedge clk) begin
    if (!rst_n || clear) fetches <= '0;
    else fetches <= sat_inc(fetches, counted && (n == 4'd2));
  end
`else
  assign fetches = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end

  // A zero divisor is detected on the first DIV cycle, giving a 2-cycle print->done path.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (print) state_nxt = DIV;
      DIV:     if ((divisor == '0) || (step == STEP_W'(FRAC_W))) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Remainder starts at hits (<= divisor), so each step keeps rem < 2*divisor.
  always_comb begin
    q_bit   = (rem >= {1'b0, divisor});
    rem_sub = q_bit ? (rem - {1'b0, divisor}) : rem;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snap_hits   <= '0;
      snap_misses <= '0;
      divisor     <= '0;
      rem         <= '0;
      quo         <= '0;
      step        <= '0;
      ratio       <= '0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (print) begin
            snap_hits   <= hits;
            snap_misses <= misses;
            divisor     <= {1'b0, hits} + {1'b0, misses};
            rem         <= {2'b00, hits};
            quo         <= '0;
            step        <= '0;
          end
        end
        DIV: begin
          quo  <= (divisor == '0) ? '0 : {quo[FRAC_W-1:0], q_bit};
          rem  <= rem_sub << 1;
          step <= step + STEP_W'(1);
        end
        FIN: begin
          ratio <= quo;
          done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_stats.sv
// Directed bench for cache_stats: default-size instance plus a tiny instance for saturation/divisor-width checks.
module tb_cache_stats;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [3:0]  n = 4'd0;
  logic        hit = 1'b0;
  logic        miss = 1'b0;

  logic [31:0] reads, writes, hits, misses, fetches, snap_hits, snap_misses;
  logic [10:0] ratio;
  logic        busy, done, proto_err;

  logic [2:0]  s_reads, s_writes, s_hits, s_misses, s_fetches, s_snap_hits, s_snap_misses;
  logic [2:0]  s_ratio;
  logic        s_busy, s_done, s_proto_err;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  cache_stats dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .n(n), .hit(hit), .miss(miss),
    .reads(reads), .writes(writes), .hits(hits), .misses(misses), .fetches(fetches),
    .snap_hits(snap_hits), .snap_misses(snap_misses), .ratio(ratio),
    .busy(busy), .done(done), .proto_err(proto_err)
  );

  cache_stats #(.CNT_W(3), .FRAC_W(2)) sdut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .n(n), .hit(hit), .miss(miss),
    .reads(s_reads), .writes(s_writes), .hits(s_hits), .misses(s_misses), .fetches(s_fetches),
    .snap_hits(s_snap_hits), .snap_misses(s_snap_misses), .ratio(s_ratio),
    .busy(s_busy), .done(s_done), .proto_err(s_proto_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [3:0] c, input logic h, input logic m);
    valid = 1'b1; n = c; hit = h; miss = m;
    tick();
    valid = 1'b0; n = 4'd0; hit = 1'b0; miss = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Cycles from now until done is seen; busy must hold on every cycle before it.
  task automatic wait_done(output int cyc, output bit busy_ok);
    cyc = 0;
    busy_ok = 1'b1;
    while (done !== 1'b1 && cyc < 100) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      tick();
      cyc++;
    end
  endtask

  initial begin
    int  cyc;
    bit  bok;
    int  pulses;

    // Reset state
    do_reset();
    chk("rst_reads", reads, 0);
    chk("rst_hits", hits, 0);
    chk("rst_ratio", ratio, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_perr", proto_err, 0);
    chk("rst_fetches", fetches, 0);

    // Strobes outside counted operations are ignored
    hit = 1'b1; tick(); hit = 1'b0;
    op(4'd5, 1'b1, 1'b0);
    op(4'd8, 1'b0, 1'b1);
    chk("ign_hits", hits, 0);
    chk("ign_misses", misses, 0);
    chk("ign_reads", reads, 0);

    // 3 reads (hit,hit,miss) + 1 write hit, then print -> 3/4
    op(4'd0, 1'b1, 1'b0);
    op(4'd0, 1'b1, 1'b0);
    op(4'd0, 1'b0, 1'b1);
    op(4'd1, 1'b1, 1'b0);
    chk("t1_reads", reads, 3);
    chk("t1_writes", writes, 1);
    chk("t1_hits", hits, 3);
    chk("t1_misses", misses, 1);
    op(4'd9, 1'b0, 1'b0);
    chk("t1_snap_hits", snap_hits, 3);
    chk("t1_snap_misses", snap_misses, 1);
    wait_done(cyc, bok);
    chk("t1_latency", cyc, 12);
    chk("t1_busy_between", bok, 1);
    chk("t1_ratio", ratio, 768);
    chk("t1_busy_after", busy, 0);
    tick();
    chk("t1_done_pulse", done, 0);

    // Clear, then print with zero counters -> 2-cycle path, ratio 0
    op(4'd8, 1'b0, 1'b0);
    chk("t2_clear_reads", reads, 0);
    chk("t2_ratio_kept", ratio, 768);
    op(4'd9, 1'b0, 1'b0);
    wait_done(cyc, bok);
    chk("t2_latency", cyc, 2);
    chk("t2_ratio", ratio, 0);

    // 4 hits, print, then clear and a read miss during DIV
    repeat (4) op(4'd0, 1'b1, 1'b0);
    op(4'd9, 1'b0, 1'b0);
    op(4'd8, 1'b0, 1'b0);
    op(4'd0, 1'b0, 1'b1);
    chk("t3_hits", hits, 0);
    chk("t3_misses", misses, 1);
    chk("t3_reads", reads, 1);
    chk("t3_busy", busy, 1);
    chk("t3_snap_hits", snap_hits, 4);
    wait_done(cyc, bok);
    chk("t3_latency", cyc, 10);
    chk("t3_ratio", ratio, 1024);

    // Second print 3 cycles after the first is ignored (hits 1, misses 1 at first print)
    op(4'd0, 1'b1, 1'b0);
    op(4'd9, 1'b0, 1'b0);
    op(4'd0, 1'b1, 1'b0);
    tick();
    op(4'd9, 1'b0, 1'b0);
    chk("t4_snap_hits", snap_hits, 1);
    wait_done(cyc, bok);
    chk("t4_latency", cyc, 9);
    chk("t4_ratio", ratio, 512);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    chk("t4_extra_done", pulses, 0);
    chk("t4_snap_kept", snap_hits, 1);

    // Protocol error: hit+miss together (hits 2, misses 1 before)
    op(4'd0, 1'b1, 1'b1);
    chk("t5_hits", hits, 3);
    chk("t5_misses", misses, 1);
    chk("t5_perr", proto_err, 1);
    op(4'd8, 1'b0, 1'b0);
    chk("t5_perr_sticky", proto_err, 1);
    op(4'd1, 1'b1, 1'b0);
    op(4'd9, 1'b0, 1'b0);
    tick();
    tick();
    chk("t5_busy_mid", busy, 1);
    rst_n = 1'b0;
    tick();
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_ratio", ratio, 0);
    chk("t5_rst_perr", proto_err, 0);
    chk("t5_rst_done", done, 0);
    rst_n = 1'b1;

    // Instruction fetches
    op(4'd2, 1'b0, 1'b1);
    op(4'd2, 1'b0, 1'b1);
    op(4'd0, 1'b1, 1'b0);
    op(4'd0, 1'b1, 1'b0);
    op(4'd9, 1'b0, 1'b0);
    wait_done(cyc, bok);
    chk("t6_latency", cyc, 12);
`ifdef STATS_FETCH_EN
    chk("t6_fetches", fetches, 2);
    chk("t6_misses", misses, 2);
    chk("t6_ratio", ratio, 512);
`else
    chk("t6_fetches", fetches, 0);
    chk("t6_misses", misses, 0);
    chk("t6_ratio", ratio, 1024);
`endif
    chk("t6_reads", reads, 2);

    // Saturation and wide divisor on the 3-bit instance: 7 hits, 7 misses -> 7*4/14 = 2
    do_reset();
    repeat (9) op(4'd0, 1'b1, 1'b0);
    chk("sat_reads", s_reads, 7);
    chk("sat_hits", s_hits, 7);
    repeat (9) op(4'd1, 1'b0, 1'b1);
    chk("sat_writes", s_writes, 7);
    chk("sat_misses", s_misses, 7);
    chk("sat_hits_hold", s_hits, 7);
    op(4'd9, 1'b0, 1'b0);
    cyc = 0;
    while (s_done !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("sat_latency", cyc, 4);
    chk("sat_ratio", s_ratio, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/cache_stats.md
Name: cache_stats

Overview:
- Statistics stage directly downstream of the L1 data cache: consumes the per-access hit/miss strobes plus the trace command code `n` for the same access.
- Keeps saturating event counters: reads, writes, hits, misses, and instruction fetches when the optional feature is compiled in.
- On a trace "print" command (`n`=9), snapshots the counters and computes a fixed-point hit ratio with a bit-serial restoring divider, for the testbench/report logic.

Parameters:
CNT_W  32  width of every event counter and snapshot register
FRAC_W  10  fractional bits of hit ratio; ratio = floor(hits*2^FRAC_W/(hits+misses))

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
valid  input  1  one-cycle strobe: `n`/`hit`/`miss` describe one trace operation this cycle
n  input  4  trace command code (0 read, 1 write, 2 ifetch, 8 clear, 9 print; others ignored)
hit  input  1  cache hit for this operation
miss  input  1  cache miss for this operation
reads  output  CNT_W  live read count
writes  output  CNT_W  live write count
hits  output  CNT_W  live hit count
misses  output  CNT_W  live miss count
fetches  output  CNT_W  live ifetch count (tied 0 without STATS_FETCH_EN)
snap_hits  output  CNT_W  hits captured at last print
snap_misses  output  CNT_W  misses captured at last print
ratio  output  FRAC_W+1  hit ratio of last completed print, unsigned Q1.FRAC_W
busy  output  1  divider running
done  output  1  one-cycle pulse when `ratio` updates
proto_err  output  1  sticky: `hit` and `miss` both high on a counted operation

Behaviour:
- Interface: one clock, `clk`; reset is synchronous and active-low, `rst_n`.
- Reset (`rst_n`=0 at a clock edge): all counters, snapshots and `ratio` go to 0. `busy`, `done` and `proto_err` go to 0. Reset aborts any running division immediately.
- Counted operation: `valid`=1 and `n` is 0 or 1 (or 2 with STATS_FETCH_EN). All updates register on that edge; outputs reflect them the next cycle.
  - `n`=0 increments `reads`; `n`=1 increments `writes`.
  - `hit`=1 increments `hits`; `miss`=1 increments `misses`.
- `proto_err` on a counted operation with `hit`=`miss`=1:
  - `proto_err` sets and stays set until reset.
  - `hits` increments; `misses` does not.
- Strobes outside counted operations: `hit`/`miss` are ignored when `valid`=0 or `n` is not counted.
- Saturation: every counter holds at 2^CNT_W-1 and never wraps.
- Clear (`valid`=1, `n`=8):
  - All live counters go to 0 on the next edge.
  - Snapshots, `ratio`, `proto_err` and a running division are unaffected.
- FSM states IDLE, DIV, FIN.
  - IDLE: on `valid`=1 and `n`=9, capture `snap_hits` and `snap_misses` from the live counters (values before any same-edge update; none is possible since `n`=9), load the divider, go to DIV. If hits+misses=0, go to FIN with quotient 0.
  - DIV: one quotient bit per cycle, MSB first, FRAC_W+1 cycles.
    - Dividend = snap_hits·2^FRAC_W; divisor = snap_hits+snap_misses, computed CNT_W+1 bits wide with no overflow.
    - Partial remainder is CNT_W+2 bits.
  - FIN: load `ratio`, pulse `done` for one cycle, return to IDLE.
- `busy`=1 in DIV and FIN.
- Latency: print edge to `done` high = FRAC_W+2 cycles (2 cycles for a zero divisor).
- A print arriving while `busy`=1 is ignored: no new snapshot, no restart.
- Counters keep updating while busy. `ratio` and the snapshots change only at FIN and at capture respectively.
- Range: `ratio` max = 2^FRAC_W, meaning all hits (1.0).

Optional Feature:
- Macro: STATS_FETCH_EN.
- Defined: `n`=2 is a counted operation. It increments `fetches` (saturating) and contributes its `hit`/`miss` to `hits`/`misses` and hence to the ratio.
- Undefined: `n`=2 is ignored entirely, and `fetches` is constant 0.

Test Plan:
- Reset, then 3 reads (hit,hit,miss) and 1 write (hit), then print -> reads=3, writes=1, hits=3, misses=1; `done` 12 cycles after print edge with `ratio`=768, `busy` high in between.
- Print with all counters 0 -> `done` 2 cycles later, `ratio`=0.
- 4 hits, print, then clear (`n`=8) and a read miss during DIV -> `ratio`=1024, snap_hits=4; after the read miss, hits=0, misses=1.
- Second print issued 3 cycles after the first -> ignored: a single `done`, snapshot from the first print.
- Counted operation with `hit`=`miss`=1 -> hits+1, misses unchanged, `proto_err`=1 until `rst_n`=0; apply reset mid-DIV -> `busy`=0 and `ratio`=0 next cycle.
- With STATS_FETCH_EN, 2 ifetch misses + 2 read hits, then print -> fetches=2, `ratio`=512; without the macro -> fetches=0, `ratio`=1024.
